// File: rtl/piso_shift.sv
// rtl/piso_shift.sv - parallel-in serial-out shifter with strobe/busy load handshake
// Optional shadow self-check enabled by defining PISO_SHADOW_EN.
module piso_shift #(
  parameter int DW        = 16,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_ce,
  input  logic          i_stb,
  input  logic [DW-1:0] i_data,
  output logic          o_busy,
  output logic          o_bit,
  output logic          o_frame,
  output logic          o_done,
  output logic          o_err
);

  localparam int             CW       = $clog2(DW);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DW - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] sreg_q, sreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          advance, last_bit, acc;

  function automatic logic [DW-1:0] shift_main(input logic [DW-1:0] v);
    if (LSB_FIRST) shift_main = {1'b0, v[DW-1:1]};
    else           shift_main = {v[DW-2:0], 1'b0};
  endfunction

  assign advance  = (state_q == SHIFT) && i_ce;
  assign last_bit = advance && (cnt_q == CNT_LAST);
  assign o_busy   = (state_q == SHIFT) && !last_bit;
  assign acc      = i_stb && !o_busy;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (acc) state_d = SHIFT;
      SHIFT:   if (last_bit && !acc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_bit   = LSB_FIRST ? sreg_q[0] : sreg_q[DW-1];
    o_frame = (state_q == SHIFT);
    o_done  = done_q;
  end

  // A reload on the final bit takes priority so back-to-back words leave no gap.
  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    done_d = last_bit;
    if (acc) begin
      sreg_d = i_data;
      cnt_d  = '0;
    end else if (last_bit) begin
      sreg_d = '0;
      cnt_d  = '0;
    end else if (advance) begin
      sreg_d = shift_main(sreg_q);
      cnt_d  = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sreg_q <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

`ifdef PISO_SHADOW_EN
  // Shadow holds the bit-reversed word and shifts the other way, so its
  // outgoing bit must always track o_bit.
  logic [DW-1:0] shadow_q, shadow_d;
  logic          shadow_bit;
  logic          err_q, err_d;

  function automatic logic [DW-1:0] bit_rev(input logic [DW-1:0] v);
    for (int i = 0; i < DW; i++) bit_rev[i] = v[DW-1-i];
  endfunction

  function automatic logic [DW-1:0] shift_shadow(input logic [DW-1:0] v);
    if (LSB_FIRST) shift_shadow = {v[DW-2:0], 1'b0};
    else           shift_shadow = {1'b0, v[DW-1:1]};
  endfunction

  assign shadow_bit = LSB_FIRST ? shadow_q[DW-1] : shadow_q[0];

  always_comb begin
    shadow_d = shadow_q;
    if (acc)           shadow_d = bit_rev(i_data);
    else if (last_bit) shadow_d = '0;
    else if (advance)  shadow_d = shift_shadow(shadow_q);
    err_d = err_q | (o_frame && (o_bit != shadow_bit));
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      shadow_q <= '0;
      err_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      err_q    <= err_d;
    end
  end

  assign o_err = err_q;

`ifdef FORMAL
  always @(posedge i_clk) begin
    if (i_reset_n) begin
      if (o_frame) assert (o_bit == shadow_bit);
      assert (32'(cnt_q) < DW);
    end
  end
`endif
`else
  assign o_err = 1'b0;
`endif

endmodule
